// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
// sync_fifo_param_if : producer/consumer bundle for sync_fifo_param
// Rev 1.0
// ============================================================================
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic [WIDTH-1:0] rdata;
  logic             valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, wdata, rd_en,
    input  rdata, valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wdata, rd_en,
    output rdata, valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// sync_fifo_param : single-clock FIFO with occupancy, thresholds, flush
// Rev 1.0
// ============================================================================
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic                clk,
  input  logic                rst,
  sync_fifo_param_if.slave    bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q;
  logic             valid_q;
  logic             overflow_q;
  logic             underflow_q;

  logic full, empty;
  logic rd_ok, wr_ok;
  logic rd_go, wr_go;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A write into a full FIFO is allowed when a read frees a slot on the same edge.
  assign rd_ok = bus.rd_en & ~empty;
  assign wr_ok = bus.wr_en & (~full | rd_ok);
  assign rd_go = rd_ok & ~bus.flush;
  assign wr_go = wr_ok & ~bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= rd_go;
      overflow_q  <= ~bus.flush & bus.wr_en & ~wr_ok;
      underflow_q <= ~bus.flush & bus.rd_en & ~rd_ok;
      if (rd_go) rdata_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_ptr_q] <= bus.wdata;
  end

  assign bus.rdata        = rdata_q;
  assign bus.valid        = valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// tb_sync_fifo_param : directed bench with a queue model of the FIFO
// Rev 1.0
// ============================================================================
module tb_sync_fifo_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [WIDTH-1:0] q [$];
  int m_rdata = 0;
  int m_valid = 0;
  int m_ovf   = 0;
  int m_udf   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit f, input bit w, input bit r,
                                     input logic [WIDTH-1:0] d);
    bit rok, wok;
    if (f) begin
      q.delete();
      m_valid = 0; m_ovf = 0; m_udf = 0;
    end else begin
      rok = r && (q.size() > 0);
      wok = w && ((q.size() < DEPTH) || rok);
      if (rok) begin
        m_rdata = int'(q.pop_front());
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      if (wok) q.push_back(d);
      m_ovf = (w && !wok) ? 1 : 0;
      m_udf = (r && !rok) ? 1 : 0;
    end
  endfunction

  task automatic step(input bit f, input bit w, input bit r, input logic [WIDTH-1:0] d);
    bus.flush = f; bus.wr_en = w; bus.rd_en = r; bus.wdata = d;
    @(posedge clk);
    model_step(f, w, r, d);
    @(negedge clk);
    bus.flush = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    q.delete();
    m_rdata = 0; m_valid = 0; m_ovf = 0; m_udf = 0;
    #1;
    chk("rst_empty",        bus.empty,        1);
    chk("rst_full",         bus.full,         0);
    chk("rst_count",        bus.count,        0);
    chk("rst_valid",        bus.valid,        0);
    chk("rst_almost_empty", bus.almost_empty, 1);
    chk("rst_overflow",     bus.overflow,     0);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",        bus.count,        q.size());
      chk("full",         bus.full,         int'(q.size() == DEPTH));
      chk("empty",        bus.empty,        int'(q.size() == 0));
      chk("almost_full",  bus.almost_full,  int'(q.size() >= AF));
      chk("almost_empty", bus.almost_empty, int'(q.size() <= AE));
      chk("valid",        bus.valid,        m_valid);
      chk("rdata",        bus.rdata,        m_rdata);
      chk("overflow",     bus.overflow,     m_ovf);
      chk("underflow",    bus.underflow,    m_udf);
    end
  end

  initial begin
    bus.flush = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wdata = '0;

    pulse_reset();
    @(negedge clk);
    chk_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'(51 + i));
      chk("fill_count",   bus.count,        i + 1);
      chk("fill_ae",      bus.almost_empty, (i + 1 <= 2) ? 1 : 0);
      chk("fill_af",      bus.almost_full,  (i + 1 >= 12) ? 1 : 0);
    end
    chk("fill_full", bus.full, 1);
    step(0, 1, 0, 8'd67);
    chk("ovf_pulse", bus.overflow, 1);
    chk("ovf_count", bus.count,    16);
    step(0, 0, 0, 8'd0);
    chk("ovf_clear", bus.overflow, 0);

    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 8'd0);
      if (i < 16) begin
        chk("drain_rdata", bus.rdata, 51 + i);
        chk("drain_valid", bus.valid, 1);
      end else begin
        chk("drain_udf",   bus.underflow, 1);
        chk("drain_novld", bus.valid,     0);
      end
    end
    chk("drain_empty", bus.empty, 1);
    chk("drain_count", bus.count, 0);

    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(80 + i));
    step(0, 1, 1, 8'd200);
    chk("fullrw_count", bus.count,    16);
    chk("fullrw_full",  bus.full,     1);
    chk("fullrw_ovf",   bus.overflow, 0);
    chk("fullrw_rdata", bus.rdata,    80);
    chk("fullrw_valid", bus.valid,    1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 8'd0);
    chk("fullrw_last",  bus.rdata,    200);
    step(0, 1, 1, 8'd33);
    chk("emptyrw_udf",   bus.underflow, 1);
    chk("emptyrw_count", bus.count,     1);
    chk("emptyrw_valid", bus.valid,     0);
    step(0, 0, 1, 8'd0);
    chk("emptyrw_data",  bus.rdata,     33);

    for (int i = 0; i < 20; i++) step(0, 1, (i >= 2), 8'(100 + i));
    step(0, 0, 1, 8'd0);
    step(0, 0, 1, 8'd0);
    chk("wrap_last", bus.rdata, 119);
    chk("wrap_empty", bus.empty, 1);

    for (int i = 0; i < 7; i++) step(0, 1, 0, 8'(10 + i));
    chk("preflush_count", bus.count, 7);
    step(1, 1, 0, 8'd99);
    chk("flush_count", bus.count, 0);
    chk("flush_empty", bus.empty, 1);
    step(0, 0, 1, 8'd0);
    chk("flush_discard", bus.underflow, 1);

    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(40 + i));
    pulse_reset();
    step(0, 1, 0, 8'd77);
    step(0, 0, 1, 8'd0);
    chk("post_rst_data", bus.rdata, 77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
